// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and line levels.
// Used by uart_rx (and its synchronizer) and by the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;  // 100 MHz / 9600 baud
  localparam int DEFAULT_DATA_BITS    = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with falling-edge detect for an asynchronous input.
// All flops reset to RESET_VAL so an idle-high line never produces a spurious edge.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = STOP_BIT
) (
  input  logic clk,
  input  logic arst_n,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-cycle done / frame_err strobes.
// Optional macro UART_RX_MAJORITY_EN votes 2-of-3 around each sample point (CLKS_PER_BIT >= 6).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the target, so every decision lands one cycle later.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF);
`else
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF - 1);
`endif
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;
  logic fall;
  logic sample;

  uart_rx_sync #(.RESET_VAL(STOP_BIT)) u_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .async_i(rx),
    .sync_o (rx_s),
    .fall_o (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) hist_q <= {2{STOP_BIT}};
    else         hist_q <= {hist_q[0], rx_s};
  end

  assign sample = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign sample = rx_s;
`endif

  uart_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 ferr_q;

  // NOTE: the shift register is reset too, so a frame cut short by reset leaves no stale bits behind.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_en && fall) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == START_LAST) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (sample == START_BIT) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;  // glitch shorter than half a bit
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            shift_q[idx_q] <= sample;
            cnt_q          <= '0;
            if (idx_q == IDX_LAST) state_q <= STOP;
            else                   idx_q   <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop lets a start edge that follows immediately be caught.
          if (cnt_q == BIT_LAST) begin
            if (sample == STOP_BIT) begin
              data_q <= shift_q;
              done_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: frames, latency, byte sweep, errors, glitch, reset, rx_en.
// Expected values follow the majority-vote timing when UART_RX_MAJORITY_EN is defined.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // start set after edge P0 -> fall seen at P3 -> stop sample at P3+HALF+9*CPB
  localparam int DONE_LAT = 3 + HALF + 9 * CPB + MAJ;

  logic       clk    = 1'b0;
  logic       arst_n = 1'b1;
  logic       rx_en  = 1'b1;
  logic       rx     = 1'b1;
  logic [7:0] data;
  logic       done;
  logic       busy;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frame_start   = 0;
  int done_cnt      = 0;
  int ferr_cnt      = 0;
  int busy_cyc      = 0;
  int last_done_cyc = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .rx_en    (rx_en),
    .rx       (rx),
    .data     (data),
    .done     (done),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (arst_n) begin
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        got_q.push_back(data);
      end
      if (frame_err) ferr_cnt++;
      if (busy) busy_cyc++;
      if (done && frame_err) begin
        failures++;
        $display("FAIL done_with_frame_err: both high at cycle %0d, required never together", cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame; optional one-cycle inverted spike at each data-bit midpoint,
  // optional rx_en drop at the start of frame bit drop_en_bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit spike,
                            input int drop_en_bit);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(posedge clk);
        #1;
        if (i == 0 && c == 0) frame_start = cyc;
        if (i == drop_en_bit && c == 0) rx_en = 1'b0;
        rx = fr[i] ^ (spike && i >= 1 && i <= 8 && c == HALF);
      end
    end
  endtask

  task automatic test_reset();
    #2 arst_n = 1'b0;
    tick(3);
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %0h expected 00", data); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    arst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_frames();
    logic [7:0] vec[5];
    logic [7:0] g;
    int d0, f0;
    vec = '{8'hF0, 8'h00, 8'hFF, 8'h91, 8'h74};
    d0 = done_cnt;
    f0 = ferr_cnt;
    got_q.delete();
    foreach (vec[i]) begin
      send_frame(vec[i], 1'b1, 1'b0, -1);
      checks++;
      if (got_q.size() == 0) begin
        failures++;
        $display("FAIL frame_data[%0d]: got no done expected %0h", i, vec[i]);
      end else begin
        g = got_q.pop_front();
        if (g !== vec[i]) begin failures++; $display("FAIL frame_data[%0d]: got %0h expected %0h", i, g, vec[i]); end
      end
    end
    last_good = 8'h74;
    checks++;
    if (done_cnt - d0 != 5) begin failures++; $display("FAIL frame_done_count: got %0d expected 5", done_cnt - d0); end
    checks++;
    if (ferr_cnt != f0) begin failures++; $display("FAIL frame_no_err: got %0d expected 0", ferr_cnt - f0); end
    tick(2);
  endtask

  task automatic test_timing();
    int d0;
    d0 = done_cnt;
    got_q.delete();
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    last_good = 8'h5A;
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL timing_done_width: got %0d high cycles expected 1", done_cnt - d0); end
    checks++;
    if (last_done_cyc - frame_start != DONE_LAT) begin
      failures++;
      $display("FAIL timing_latency: got %0d expected %0d", last_done_cyc - frame_start, DONE_LAT);
    end
    tick(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] g;
    int d0;
    d0 = done_cnt;
    got_q.delete();
    for (int b = 0; b < 256; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, -1);
      checks++;
      if (got_q.size() == 0) begin
        failures++;
        $display("FAIL sweep[%0d]: got no done expected %0h", b, b);
      end else begin
        g = got_q.pop_front();
        if (g !== 8'(b)) begin failures++; $display("FAIL sweep[%0d]: got %0h expected %0h", b, g, b); end
      end
    end
    last_good = 8'hFF;
    checks++;
    if (done_cnt - d0 != 256) begin failures++; $display("FAIL sweep_count: got %0d expected 256", done_cnt - d0); end
    tick(2);
  endtask

  task automatic test_frame_err();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, -1);
    rx = 1'b1;
    tick(CPB);
    checks++;
    if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0); end
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL ferr_no_done: got %0d expected 0", done_cnt - d0); end
    checks++;
    if (data !== last_good) begin failures++; $display("FAIL ferr_data_kept: got %0h expected %0h", data, last_good); end
  endtask

  task automatic test_break();
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b0, 1'b0, -1);
    tick(2 * 10 * CPB);
    checks++;
    if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL break_one_err: got %0d expected 1", ferr_cnt - f0); end
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL break_no_done: got %0d expected 0", done_cnt - d0); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL break_idle: got busy %b expected 0", busy); end
    rx = 1'b1;
    tick(CPB);
  endtask

  task automatic test_glitch();
    logic [7:0] g;
    int d0, f0, b0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    b0 = busy_cyc;
    got_q.delete();
    tick(1);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * CPB);
    checks++;
    if (busy_cyc - b0 != HALF + MAJ) begin failures++; $display("FAIL glitch_busy: got %0d cycles expected %0d", busy_cyc - b0, HALF + MAJ); end
    checks++;
    if (done_cnt != d0 || ferr_cnt != f0) begin
      failures++;
      $display("FAIL glitch_flags: got done %0d ferr %0d expected 0 0", done_cnt - d0, ferr_cnt - f0);
    end
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    last_good = 8'h3C;
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL glitch_then_frame: got %0d dones expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 8'h3C) begin failures++; $display("FAIL glitch_then_frame: got %0h expected 3c", g); end
    end
    tick(2);
  endtask

  task automatic test_reset_mid();
    logic [9:0] fr;
    logic [7:0] g;
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (i == 5 && c == HALF) break;
        @(posedge clk);
        #1;
        rx = fr[i];
      end
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    arst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (data !== 8'h00) begin failures++; $display("FAIL rstmid_data: got %0h expected 00", data); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_flags: got busy %b done %b ferr %b expected 0 0 0", busy, done, frame_err);
    end
    rx = 1'b1;
    tick(2);
    arst_n = 1'b1;
    tick(3);
    got_q.delete();
    send_frame(8'hAA, 1'b1, 1'b0, -1);
    last_good = 8'hAA;
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL rstmid_after: got %0d dones expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 8'hAA) begin failures++; $display("FAIL rstmid_after: got %0h expected aa", g); end
    end
    tick(2);
  endtask

  task automatic test_rx_en();
    logic [7:0] g;
    int d0, b0;
    got_q.delete();
    rx_en = 1'b1;
    send_frame(8'h6B, 1'b1, 1'b0, 4);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL rxen_finish_frame: got %0d dones expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 8'h6B) begin failures++; $display("FAIL rxen_finish_frame: got %0h expected 6b", g); end
    end
    d0 = done_cnt;
    b0 = busy_cyc;
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    tick(2);
    checks++;
    if (done_cnt != d0 || busy_cyc != b0) begin
      failures++;
      $display("FAIL rxen_blocked: got done %0d busy %0d expected 0 0", done_cnt - d0, busy_cyc - b0);
    end
    rx_en = 1'b1;
    tick(CPB);
    send_frame(8'h2D, 1'b1, 1'b0, -1);
    last_good = 8'h2D;
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL rxen_rearm: got %0d dones expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== 8'h2D) begin failures++; $display("FAIL rxen_rearm: got %0h expected 2d", g); end
    end
    tick(2);
  endtask

  task automatic test_majority();
    logic [7:0] g;
    logic [7:0] exp_b;
    exp_b = (MAJ != 0) ? 8'h0F : 8'hF0;
    got_q.delete();
    send_frame(8'h0F, 1'b1, 1'b1, -1);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL spike_data: got %0d dones expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== exp_b) begin failures++; $display("FAIL spike_data: got %0h expected %0h", g, exp_b); end
    end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_timing();
    test_back_to_back();
    test_frame_err();
    test_break();
    test_glitch();
    test_reset_mid();
    test_rx_en();
    test_majority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Consumes the serial line driven by the existing UART_TX: 8N1 frame, LSB first, idle high.
- Converts the frame back to a parallel byte, with a one-cycle done strobe and error flagging.
- Sits on the RX pin side of the UART top. Loopback TX->RX is the primary system-level check.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per bit (100 MHz / 9600 baud); must be >= 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- rx_en  in  1  arms reception of new frames.
- rx  in  1  asynchronous serial input.
- data  out  DATA_BITS  last good received byte.
- done  out  1  one-cycle pulse: data updated.
- busy  out  1  high while a frame is in progress (START..STOP).
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset (arst_n=0, asynchronous):
  - state=IDLE, data=0, done=0, busy=0, frame_err=0, counters=0.
  - Both synchronizer flops reset to 1 so the idle-high line gives no false start.
- rx passes a 2-flop synchronizer (rx_s). fall = rx_s_prev & ~rx_s.
- HALF = CLKS_PER_BIT/2 (integer divide).
- Bit counter width is clog2(CLKS_PER_BIT). Bit index counter is 3 bits.
- FSM:
  - IDLE: if rx_en & fall -> START, cnt=0, busy=1.
  - START: cnt increments. At cnt==HALF-1, sample rx_s:
    - 0 -> DATA, cnt=0, idx=0.
    - 1 -> glitch; return to IDLE, busy=0, no flags.
  - DATA: at cnt==CLKS_PER_BIT-1, sample into shift register bit idx (LSB first) and reset cnt. After idx==DATA_BITS-1 -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample:
    - 1 -> data<=shift register, done=1.
    - 0 -> frame_err=1, data unchanged.
    - Either way -> IDLE, busy=0.
- Timing:
  - Samples land at mid-bit: fall detection cycle + HALF + k*CLKS_PER_BIT, k=0..9.
  - done/frame_err are high exactly in the cycle after the stop sample, one cycle wide.
  - Because IDLE is re-entered half a bit early, a back-to-back next frame (start edge right after the stop bit) is caught.
- rx_en deasserted mid-frame: the current frame completes normally; only new frames are blocked.
- Break (rx held low): frame_err pulses once. No new frame starts until rx_s returns high and falls again, because edge detection is required.
- arst_n asserted mid-frame: immediate return to reset values; the partial byte is discarded.
- done and frame_err are never high together.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point takes three rx_s values at cycles target-1, target, target+1 and uses the majority (2 of 3).
  - The state/counter transition occurs at target+1. done and frame_err therefore move one cycle later than without the macro.
  - Requires CLKS_PER_BIT >= 6.
- Undefined: single sample at target; timing as in Behaviour.

Decomposition:
- Shared package uart_pkg:
  - state encodings IDLE/START/DATA/STOP (2 bits).
  - default CLKS_PER_BIT=10417 and DATA_BITS=8.
  - frame constants START_BIT=0, STOP_BIT=1, also reused by UART_TX.
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detect, with reset value 1. Reusable for other async inputs.

Test Plan:
- Frames 8'hF0, 8'h00, 8'hFF, 8'h91, 8'h74 in 8N1 at CLKS_PER_BIT=16 -> done pulses once per frame, data equals each byte, frame_err=0.
- Loopback at default: UART_TX with data=8'hC1 driving rx -> done within 10*10417+4 cycles of tx_en, data=8'hC1. Sweep all 256 bytes at CLKS_PER_BIT=16.
- 8'hA5 frame with stop bit forced 0 -> frame_err one cycle, done=0, data keeps the previous value. Hold rx low 3 frames -> exactly one frame_err.
- 3-cycle low glitch on idle rx (CLKS_PER_BIT=16) -> no busy beyond START, no done, no frame_err. Then a valid 8'h3C is received correctly.
- Assert arst_n=0 during bit 4 of 8'h55 -> all outputs 0 next cycle. After release, frame 8'hAA -> data=8'hAA.
- With UART_RX_MAJORITY_EN, 1-cycle inverted spike at the mid-point of each data bit of 8'h0F -> data=8'h0F. Without the macro the same stimulus corrupts data (documents the feature).
